carry_skip_adder: RTL and testbench

- Parameterised N-bit binary adder with carry-in, built as ripple-carry blocks of BLOCK_SIZE bits plus per-block carry-skip (bypass) logic.
- Result and carry-out are captured in an output register, giving one cycle of latency.
- Used as a datapath arithmetic primitive where a registered, area-efficient adder faster than plain ripple is needed.

---
 rtl/carry_skip_adder.sv | 79 +++++++
 tb/tb_carry_skip_adder.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/carry_skip_adder.sv
// carry_skip_adder: registered N-bit carry-skip adder; define CARRY_SKIP_ADDER_OVF_EN to add signed overflow output ovf
module carry_skip_adder #(
  parameter int BLOCK_SIZE = 4,
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  output logic [N-1:0] sum,
`ifdef CARRY_SKIP_ADDER_OVF_EN
  output logic         cout,
  output logic         ovf
`else
  output logic         cout
`endif
);
  logic [N-1:0] w_p, w_g, w_sum;
  logic         w_c, w_bc, w_pk;
  logic [N-1:0] r_sum;
  logic         r_cout, r_valid;
`ifdef CARRY_SKIP_ADDER_OVF_EN
  logic         w_cmsb, r_ovf;
`endif
  assign w_p = a ^ b;
  assign w_g = a & b;
  // ripple within each block; a fully propagating block forwards its carry-in straight out
  always_comb begin
    w_c = cin;
    w_bc = 1'b0;
    w_pk = 1'b0;
    w_sum = '0;
`ifdef CARRY_SKIP_ADDER_OVF_EN
    w_cmsb = 1'b0;
`endif
    for (int i = 0; i < N; i++) begin
      if (i % BLOCK_SIZE == 0) begin
        w_bc = w_c;
        w_pk = 1'b1;
      end
`ifdef CARRY_SKIP_ADDER_OVF_EN
      if (i == N - 1) w_cmsb = w_c;
`endif
      w_sum[i] = w_p[i] ^ w_c;
      w_c = w_g[i] | (w_p[i] & w_c);
      w_pk = w_pk & w_p[i];
      if (i % BLOCK_SIZE == BLOCK_SIZE - 1 || i == N - 1) w_c = w_pk ? w_bc : w_c;
    end
  end
  // capture accepted results; out_valid marks a result loaded on the previous edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum <= '0;
      r_cout <= 1'b0;
      r_valid <= 1'b0;
`ifdef CARRY_SKIP_ADDER_OVF_EN
      r_ovf <= 1'b0;
`endif
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_sum <= w_sum;
        r_cout <= w_c;
`ifdef CARRY_SKIP_ADDER_OVF_EN
        r_ovf <= w_cmsb ^ w_c;
`endif
      end
    end
  end
  assign sum = r_sum;
  assign cout = r_cout;
  assign out_valid = r_valid;
`ifdef CARRY_SKIP_ADDER_OVF_EN
  assign ovf = r_ovf;
`endif
endmodule

// File: tb/tb_carry_skip_adder.sv
// tb_carry_skip_adder: directed checks of carry_skip_adder at N=1, 8 and 10
module tb_carry_skip_adder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic       cin = 1'b0;
  logic [0:0] a1 = '0, b1 = '0, s1;
  logic [7:0] a8 = '0, b8 = '0, s8;
  logic [9:0] a10 = '0, b10 = '0, s10;
  logic       co1, co8, co10, v1, v8, v10;
`ifdef CARRY_SKIP_ADDER_OVF_EN
  logic       ovf1, ovf8, ovf10;
`endif
  int checks = 0;
  int errors = 0;
  logic [4:0] tab1 [8] = '{5'b10101, 5'b11111, 5'b01101, 5'b00110,
                           5'b01010, 5'b10010, 5'b11001, 5'b00000};
  logic [4:0]  t;
  logic [10:0] e;

  always #5 clk = ~clk;

  carry_skip_adder #(.BLOCK_SIZE(4), .N(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a1), .b(b1), .cin(cin),
    .out_valid(v1), .sum(s1),
`ifdef CARRY_SKIP_ADDER_OVF_EN
    .cout(co1), .ovf(ovf1)
`else
    .cout(co1)
`endif
  );
  carry_skip_adder #(.BLOCK_SIZE(4), .N(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a8), .b(b8), .cin(cin),
    .out_valid(v8), .sum(s8),
`ifdef CARRY_SKIP_ADDER_OVF_EN
    .cout(co8), .ovf(ovf8)
`else
    .cout(co8)
`endif
  );
  carry_skip_adder #(.BLOCK_SIZE(4), .N(10)) dut10 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a10), .b(b10), .cin(cin),
    .out_valid(v10), .sum(s10),
`ifdef CARRY_SKIP_ADDER_OVF_EN
    .cout(co10), .ovf(ovf10)
`else
    .cout(co10)
`endif
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic c);
    @(negedge clk);
    in_valid = iv;
    cin = c;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("rst_sum8", 16'(s8), 16'h0);
    chk("rst_cout8", 16'(co8), 16'h0);
    chk("rst_valid8", 16'(v8), 16'h0);
    chk("rst_valid10", 16'(v10), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      t = tab1[i];
      drive(1'b1, t[2]);
      a1 = t[4:4];
      b1 = t[3:3];
      step();
      chk("n1_sum", 16'(s1), 16'(t[1]));
      chk("n1_cout", 16'(co1), 16'(t[0]));
      chk("n1_valid", 16'(v1), 16'h1);
    end
    drive(1'b1, 1'b1);
    a8 = 8'hFF; b8 = 8'h00;
    a10 = 10'h155; b10 = 10'h0AA;
    step();
    chk("skip_sum", 16'(s8), 16'h00);
    chk("skip_cout", 16'(co8), 16'h1);
    chk("part2_sum", 16'(s10), 16'h200);
    chk("part2_cout", 16'(co10), 16'h0);
    drive(1'b1, 1'b0);
    a10 = 10'h3FF; b10 = 10'h001;
    step();
    chk("noskip_sum", 16'(s8), 16'hFF);
    chk("noskip_cout", 16'(co8), 16'h0);
    chk("part1_sum", 16'(s10), 16'h000);
    chk("part1_cout", 16'(co10), 16'h1);
    drive(1'b1, 1'b0);
    a8 = 8'h12; b8 = 8'h34;
    step();
    chk("hold_sum0", 16'(s8), 16'h46);
    chk("hold_valid0", 16'(v8), 16'h1);
    drive(1'b0, 1'b1);
    a8 = 8'hFF; b8 = 8'hFF;
    step();
    chk("hold_valid1", 16'(v8), 16'h0);
    chk("hold_sum1", 16'(s8), 16'h46);
    chk("hold_cout1", 16'(co8), 16'h0);
    step();
    chk("hold_valid2", 16'(v8), 16'h0);
    chk("hold_sum2", 16'(s8), 16'h46);
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'($urandom));
      a10 = 10'($urandom);
      b10 = 10'($urandom);
      e = {1'b0, a10} + {1'b0, b10} + {10'b0, cin};
      step();
      chk("stream_res", 16'({co10, s10}), 16'(e));
      chk("stream_valid", 16'(v10), 16'h1);
    end
`ifdef CARRY_SKIP_ADDER_OVF_EN
    drive(1'b1, 1'b0);
    a8 = 8'h7F; b8 = 8'h01;
    step();
    chk("ovf1_sum", 16'(s8), 16'h80);
    chk("ovf1_cout", 16'(co8), 16'h0);
    chk("ovf1_ovf", 16'(ovf8), 16'h1);
    drive(1'b1, 1'b0);
    a8 = 8'h80; b8 = 8'h80;
    step();
    chk("ovf2_sum", 16'(s8), 16'h00);
    chk("ovf2_cout", 16'(co8), 16'h1);
    chk("ovf2_ovf", 16'(ovf8), 16'h1);
`endif
    drive(1'b1, 1'b1);
    a8 = 8'hFF; b8 = 8'hFF;
    step();
    chk("ones_sum", 16'(s8), 16'hFF);
    chk("ones_cout", 16'(co8), 16'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_sum", 16'(s8), 16'h0);
    chk("async_cout", 16'(co8), 16'h0);
    chk("async_valid", 16'(v8), 16'h0);
    step();
    chk("inrst_sum", 16'(s8), 16'h0);
    chk("inrst_valid", 16'(v8), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
